// File: rtl/bm_mem_arb.sv
// Single-port arbiter for the bitmatrix SRAM: host writes vs. bm_cntl column reads.
// Optional read starvation guard: define BM_ARB_STARVE_GUARD_EN.
module bm_mem_arb #(
   parameter int BM_COL_W      = 64,
   parameter int BM_MEM_ADDR_W = 8,
   parameter int MEM_RD_LAT    = 2,
   parameter int STARVE_MAX    = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     eng_rstn,
   input  logic                     rd_rq,
   input  logic [BM_MEM_ADDR_W-1:0] rd_addr,
   output logic                     rd_gnt,
   output logic [BM_COL_W-1:0]      rd_data,
   output logic                     rd_data_val,
   input  logic                     wr_rq,
   input  logic [BM_MEM_ADDR_W-1:0] wr_addr,
   input  logic [BM_COL_W-1:0]      wr_data,
   output logic                     wr_gnt,
   output logic                     mem_en,
   output logic                     mem_wr_en,
   output logic [BM_MEM_ADDR_W-1:0] mem_addr,
   output logic [BM_COL_W-1:0]      mem_wr_data,
   input  logic [BM_COL_W-1:0]      mem_rd_data,
   output logic                     arb_busy
);

   localparam int STAGES = MEM_RD_LAT + 1;

   if (MEM_RD_LAT < 1 || STARVE_MAX < 1) begin : g_bad_cfg
      $error("bm_mem_arb: MEM_RD_LAT and STARVE_MAX must be >= 1");
   end

   // Encoding chosen so the SRAM strobes are the state flops themselves.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b11
   } own_e;

   own_e              own;
   logic [STAGES-1:0] vld_pipe;
   logic              rd_elig;
   logic              starve;

   assign rd_elig = rd_rq & eng_rstn;

`ifdef BM_ARB_STARVE_GUARD_EN
   localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;

   assign starve = (starve_cnt == STARVE_LIM);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                   starve_cnt <= '0;
      else if (!eng_rstn || rd_gnt) starve_cnt <= '0;
      else if (rd_elig && !starve)  starve_cnt <= starve_cnt + CNT_W'(1);
   end
`else
   assign starve = 1'b0;
`endif

   // Write wins unless the guard has saturated; grants vanish while in reset.
   assign rd_gnt = rstn & rd_elig & (~wr_rq | starve);
   assign wr_gnt = rstn & wr_rq & ~rd_gnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         own         <= IDLE;
         mem_addr    <= '0;
         mem_wr_data <= '0;
      end else if (wr_gnt) begin
         own         <= WR;
         mem_addr    <= wr_addr;
         mem_wr_data <= wr_data;
      end else if (rd_gnt) begin
         own         <= RD;
         mem_addr    <= rd_addr;
      end else begin
         own         <= IDLE;
      end
   end

   assign mem_en    = own[0];
   assign mem_wr_en = own[1];

   // Soft reset flushes in-flight reads so their data is never reported.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         vld_pipe <= '0;
      else if (!eng_rstn) vld_pipe <= '0;
      else               vld_pipe <= {vld_pipe[STAGES-2:0], rd_gnt};
   end

   assign rd_data_val = vld_pipe[STAGES-1];
   assign rd_data     = rd_data_val ? mem_rd_data : '0;
   assign arb_busy    = mem_en | (|vld_pipe);

endmodule

// File: tb/tb_bm_mem_arb.sv
// Bench for bm_mem_arb: vector table, directed corner sequences and a random run
// against a grant-order scoreboard with a shadow copy of the SRAM.
module tb_bm_mem_arb;
   localparam int CW   = 64;
   localparam int AW   = 8;
   localparam int LAT  = 2;
   localparam int SMAX = 8;
   localparam logic [CW-1:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

   logic          clk = 1'b0;
   logic          rstn = 1'b0, eng_rstn = 1'b1;
   logic          rd_rq = 1'b0, wr_rq = 1'b0;
   logic [AW-1:0] rd_addr = '0, wr_addr = '0;
   logic [CW-1:0] wr_data = '0;
   logic          rd_gnt, wr_gnt, rd_data_val, mem_en, mem_wr_en, arb_busy;
   logic [CW-1:0] rd_data, mem_wr_data;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] mem_rd_data = '0;

   always #5 clk = ~clk;

   bm_mem_arb #(.BM_COL_W(CW), .BM_MEM_ADDR_W(AW), .MEM_RD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn),
      .rd_rq(rd_rq), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_data_val(rd_data_val),
      .wr_rq(wr_rq), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data), .arb_busy(arb_busy)
   );

   // SRAM model: two-cycle read latency from the registered command, plus a preload port.
   logic [CW-1:0] sram [256];
   logic [CW-1:0] rd_p1 = '0;
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [CW-1:0] bd_data = '0;

   always @(posedge clk) begin
      if (bd_we) sram[bd_addr] <= bd_data;
      else if (mem_en && mem_wr_en) sram[mem_addr] <= mem_wr_data;
      rd_p1       <= sram[mem_addr];
      mem_rd_data <= rd_p1;
   end

   // Reference model state
   typedef struct { int due; logic [CW-1:0] d; } rd_t;
   rd_t           pend[$];
   logic [CW-1:0] shadow [256];
   logic          x_en = 1'b0, x_we = 1'b0;
   logic [AW-1:0] x_addr = '0;
   logic [CW-1:0] x_wd = '0;
   int            streak = 0;
   int            cyc = 0;
   int            errs = 0, checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Called at a negedge: drive one cycle, check against the model, advance to next negedge.
   task automatic step(input logic r, input logic w, input logic e,
                       input logic [AW-1:0] ra, input logic [AW-1:0] wa, input logic [CW-1:0] wd,
                       output logic rg, output logic wg);
      logic er, ew, sv, ev;
      logic [CW-1:0] ed;
      rd_t it;
      rd_rq = r; wr_rq = w; eng_rstn = e; rd_addr = ra; wr_addr = wa; wr_data = wd;
      #1;
      sv = 1'b0;
`ifdef BM_ARB_STARVE_GUARD_EN
      sv = (streak == SMAX);
`endif
      er = r & e & (~w | sv);
      ew = w & ~er;
      ev = (pend.size() != 0) && (pend[0].due == cyc);
      ed = ev ? pend[0].d : '0;
      chk("rd_gnt", rd_gnt, er);
      chk("wr_gnt", wr_gnt, ew);
      chk("rd_data_val", rd_data_val, ev);
      chk("rd_data", rd_data, ed);
      chk("mem_en", mem_en, x_en);
      chk("mem_wr_en", mem_wr_en, x_we);
      if (x_en) chk("mem_addr", mem_addr, x_addr);
      if (x_en && x_we) chk("mem_wr_data", mem_wr_data, x_wd);
      chk("arb_busy", arb_busy, x_en | (pend.size() != 0));
      rg = rd_gnt; wg = wr_gnt;
      if (ev) void'(pend.pop_front());
      if (!e) pend.delete();
      if (!e || er) streak = 0;
      else if (r && streak < SMAX) streak++;
      if (er) begin
         it.due = cyc + 1 + LAT;
         it.d   = shadow[ra];
         pend.push_back(it);
      end
      if (ew) shadow[wa] = wd;
      x_en = er | ew; x_we = ew; x_addr = ew ? wa : ra; x_wd = wd;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   typedef struct { logic r, w, e, xr, xw; string nm; } vec_t;
   vec_t tbl [10];

   initial begin
      logic rg, wg;
      logic [CW-1:0] init_v;

      tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "idle"};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "rd_only"};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "wr_only"};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "cont1"};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "cont2"};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "cont3"};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "cont4"};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "cont_rd5"};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "eng_rd_block"};
      tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "eng_wr_pass"};

      // Reset state while held in reset
      #2;
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_wr_en", mem_wr_en, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_rd_data_val", rd_data_val, 1'b0);
      chk("rst_arb_busy", arb_busy, 1'b0);

      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         init_v = (a == 5) ? PAT_A5 : {8{a[7:0]}};
         bd_we = 1'b1; bd_addr = a[7:0]; bd_data = init_v;
         shadow[a] = init_v;
      end
      @(negedge clk);
      bd_we = 1'b0;
      rstn = 1'b1;

      // Vector table
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].r, tbl[i].w, tbl[i].e, 8'(i + 32), 8'(i + 64), {32'hC0DE0000, i}, rg, wg);
         chk({"tbl_rg_", tbl[i].nm}, rg, tbl[i].xr);
         chk({"tbl_wg_", tbl[i].nm}, wg, tbl[i].xw);
      end
      step(0, 0, 1, '0, '0, '0, rg, wg);

      // Single read of preloaded address 0x05
      step(1, 0, 1, 8'h05, '0, '0, rg, wg);
      chk("single_mem_en", mem_en, 1'b1);
      chk("single_mem_wr_en", mem_wr_en, 1'b0);
      chk("single_mem_addr", mem_addr, 8'h05);
      step(0, 0, 1, '0, '0, '0, rg, wg);
      step(0, 0, 1, '0, '0, '0, rg, wg);
      chk("single_val", rd_data_val, 1'b1);
      chk("single_data", rd_data, PAT_A5);
      step(0, 0, 1, '0, '0, '0, rg, wg);

      // Write then read the same address
      step(0, 1, 1, '0, 8'h10, 64'h1234, rg, wg);
      step(1, 0, 1, 8'h10, '0, '0, rg, wg);
      step(0, 0, 1, '0, '0, '0, rg, wg);
      step(0, 0, 1, '0, '0, '0, rg, wg);
      chk("wr_rd_val", rd_data_val, 1'b1);
      chk("wr_rd_data", rd_data, 64'h1234);
      step(0, 0, 1, '0, '0, '0, rg, wg);

      // Soft reset with two reads in flight and a write in the same cycle
      step(1, 0, 1, 8'h01, '0, '0, rg, wg);
      step(1, 0, 1, 8'h02, '0, '0, rg, wg);
      step(0, 1, 0, '0, 8'h33, 64'hBEEF, rg, wg);
      chk("soft_wr_mem_en", mem_en, 1'b1);
      chk("soft_wr_mem_wr_en", mem_wr_en, 1'b1);
      chk("soft_wr_mem_addr", mem_addr, 8'h33);
      for (int i = 0; i < 3; i++) begin
         chk("soft_no_val", rd_data_val, 1'b0);
         step(0, 0, 1, '0, '0, '0, rg, wg);
      end

`ifdef BM_ARB_STARVE_GUARD_EN
      // Both held: read forced on the ninth cycle, then write resumes
      for (int i = 0; i < 9; i++) begin
         step(1, 1, 1, 8'h07, 8'h08, 64'h55, rg, wg);
         chk("starve_rg", rg, i == 8);
         chk("starve_wg", wg, i != 8);
      end
      step(1, 1, 1, 8'h07, 8'h08, 64'h56, rg, wg);
      chk("starve_wr_resume", wg, 1'b1);
      step(0, 0, 1, '0, '0, '0, rg, wg);
`endif

      // Async reset mid-read
      step(1, 0, 1, 8'h05, '0, '0, rg, wg);
      rd_rq = 1'b1; wr_rq = 1'b1;
      #2 rstn = 1'b0;
      #1;
      chk("arst_rd_gnt", rd_gnt, 1'b0);
      chk("arst_wr_gnt", wr_gnt, 1'b0);
      chk("arst_mem_en", mem_en, 1'b0);
      chk("arst_mem_wr_en", mem_wr_en, 1'b0);
      chk("arst_mem_addr", mem_addr, '0);
      chk("arst_mem_wr_data", mem_wr_data, '0);
      chk("arst_rd_data_val", rd_data_val, 1'b0);
      chk("arst_rd_data", rd_data, '0);
      chk("arst_arb_busy", arb_busy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rd_rq = 1'b0; wr_rq = 1'b0;
      rstn = 1'b1;
      pend.delete(); x_en = 1'b0; x_we = 1'b0; streak = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, '0, '0, '0, rg, wg);
         chk("arst_no_val", rd_data_val, 1'b0);
      end

      // Randomized traffic on a small address window to exercise same-address ordering
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0),
              8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), {$urandom, $urandom}, rg, wg);
      end
      for (int i = 0; i < 5; i++) step(0, 0, 1, '0, '0, '0, rg, wg);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/bm_mem_arb.md
# bm_mem_arb

Single-port arbiter for the bitmatrix SRAM, shared between the bitmatrix control read path (column fetches during encoding) and the host write path that loads bitmatrix columns. It grants at most one access per cycle, registers the SRAM command, and tracks read latency so read data is returned to the reader with a valid strobe. It sits between `bm_cntl` and the bitmatrix memory inside the control block.

## Interface
- `BM_COL_W`, 64: bitmatrix column / SRAM data width
- `BM_MEM_ADDR_W`, 8: SRAM address width
- `MEM_RD_LAT`, 2: SRAM read latency in cycles from registered command to data, minimum 1
- `STARVE_MAX`, 8: consecutive denied read cycles before a forced read grant (guard builds only)

- `clk` in 1: clock
- `rstn` in 1: asynchronous active-low reset
- `eng_rstn` in 1: engine soft reset, active low, synchronous
- `rd_rq` in 1: read request from `bm_cntl` (level)
- `rd_addr` in BM_MEM_ADDR_W: read address
- `rd_gnt` out 1: read accepted this cycle (combinational)
- `rd_data` out BM_COL_W: read data to `bm_cntl`
- `rd_data_val` out 1: `rd_data` valid
- `wr_rq` in 1: host write request (level)
- `wr_addr` in BM_MEM_ADDR_W: write address
- `wr_data` in BM_COL_W: write data
- `wr_gnt` out 1: write accepted this cycle (combinational)
- `mem_en` out 1: SRAM enable (registered)
- `mem_wr_en` out 1: SRAM write enable (registered)
- `mem_addr` out BM_MEM_ADDR_W: SRAM address (registered)
- `mem_wr_data` out BM_COL_W: SRAM write data (registered)
- `mem_rd_data` in BM_COL_W: SRAM read data
- `arb_busy` out 1: any command issued or read in flight

## Operation
- Per cycle: grant at most one requester; the granted command is registered onto the `mem_*` ports the next cycle.
- Owner FSM, states IDLE, WR, RD (last granted access):
  - IDLE/WR/RD -> WR when `wr_gnt`; -> RD when `rd_gnt`; -> IDLE when no grant.
- Base policy: write has strict priority. `rd_gnt = rd_rq & eng_rstn & ~wr_rq`, `wr_gnt = wr_rq`, except where the starvation guard overrides.
- In-flight tracker: a valid shift register of depth 1+MEM_RD_LAT, loaded with `rd_gnt`. `rd_data_val` is the last stage; `rd_data = mem_rd_data` passed through combinationally, and is 0 when not valid.
- Same-address write/read ordering follows grant order. There is no reordering or forwarding.
- `eng_rstn` low: `rd_gnt` is forced 0, the in-flight tracker is cleared (pending reads never raise `rd_data_val`), and the starve counter is cleared. Writes are unaffected.
- `rstn` low (async): all outputs and state go to 0 and the FSM goes to IDLE. Reset mid-read drops the read.
- `arb_busy = mem_en | (|tracker)`.

## Timing
- Grant to `mem_en` high: 1 cycle. Read grant to `rd_data_val`: 1+MEM_RD_LAT cycles (3 at default).
- Back-to-back grants produce back-to-back `mem_*` commands and back-to-back `rd_data_val`. Throughput is 1 access per cycle.
- Request with no grant: the requester holds `rq`/addr/data stable until granted.
- Reset value of every output: 0.

## Configuration
- `BM_ARB_STARVE_GUARD_EN` defined:
  - A saturating counter (width clog2(STARVE_MAX+1)) increments each cycle that `rd_rq & eng_rstn & ~rd_gnt` holds.
  - When the counter equals STARVE_MAX, read wins the next contention: `rd_gnt=1`, `wr_gnt=0`.
  - The counter clears on `rd_gnt`.
- Not defined: strict write priority; the counter is not built.

## Test plan
- Reset: `rstn` low mid-read at default params -> all outputs 0 immediately, no `rd_data_val` after release.
- Single read: `rd_rq` at addr 0x05 with the SRAM preloaded 0xA5A5... -> `mem_en=1`, `mem_wr_en=0`, `mem_addr=0x05` at +1, `rd_data_val` with data 0xA5A5... at +3.
- Contention: `wr_rq` and `rd_rq` high together for 4 cycles, guard off -> 4 `wr_gnt`, 0 `rd_gnt`, then `rd_gnt` on cycle 5.
- Starvation: guard on, STARVE_MAX=8, both requests held continuously -> `rd_gnt` on the 9th cycle, then write resumes.
- Soft reset: reads granted at cycles 0,1 and `eng_rstn` low at cycle 2 -> no `rd_data_val`; a write granted during cycle 2 reaches `mem_*` at cycle 3.
- Write-then-read same address 0x10, data 0x1234 -> read returns 0x1234.
